// File: rtl/axis_data_unpack.sv
// axis_data_unpack: receive-side unpacker for framed difftest packets on a
// 512-bit AXI-Stream. Each packet spans BEATS_PER_PKT beats with an 8-bit
// header in the low byte of beat 0. Headers are stripped and whole packets
// are presented on a valid/ready holding register.
// Optional build macro: AXIS_UNPACK_SEQ_CHECK_EN enables sequence checking
// (exp_seq tracking and err_seq pulses); without it err_seq is tied low.
module axis_data_unpack #(
  parameter int DATA_WIDTH      = 16000,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int PKTS_PER_XFER   = 8
) (
  input  logic                       s_axis_h2c_aclk,
  input  logic                       s_axis_h2c_areset,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_h2c_tdata,
  input  logic [63:0]                s_axis_h2c_tkeep,
  input  logic                       s_axis_h2c_tlast,
  input  logic                       s_axis_h2c_tvalid,
  output logic                       s_axis_h2c_tready,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic [DATA_WIDTH-1:0]      data,
  output logic [7:0]                 rx_seq,
  output logic                       err_seq,
  output logic                       err_frame
);

  localparam int BEATS_PER_PKT = (DATA_WIDTH + 8 + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
  localparam int ASM_W         = BEATS_PER_PKT * AXIS_DATA_WIDTH;
  localparam int BW            = (BEATS_PER_PKT > 1) ? $clog2(BEATS_PER_PKT) : 1;
  localparam int PW            = (PKTS_PER_XFER > 1) ? $clog2(PKTS_PER_XFER) : 1;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t            state, state_next;
  logic [BW-1:0]     beat_cnt, beat_cnt_next;
  logic [PW-1:0]     pkt_cnt, pkt_cnt_next;
  logic [ASM_W-1:0]  asm_q, asm_next;

  logic accept, last_beat, last_pkt, xfer_end, first_beat;
  logic early_last, missing_last, load;
  logic [7:0] header;

  assign header       = s_axis_h2c_tdata[7:0];
  assign accept       = s_axis_h2c_tvalid & s_axis_h2c_tready;
  assign last_beat    = (beat_cnt == BW'(BEATS_PER_PKT - 1));
  assign last_pkt     = (pkt_cnt == PW'(PKTS_PER_XFER - 1));
  assign xfer_end     = last_beat & last_pkt;
  assign first_beat   = (beat_cnt == '0) & (pkt_cnt == '0);
  assign early_last   = accept & s_axis_h2c_tlast & ~xfer_end;
  assign missing_last = accept & xfer_end & ~s_axis_h2c_tlast;
  // A packet completed by its own last beat is delivered even when tlast
  // arrives early on it; only a truly partial packet is dropped.
  assign load         = accept & last_beat;

  // Only the beat that would load a still-occupied holding register stalls.
  assign s_axis_h2c_tready = ~(last_beat & data_valid & ~data_ready);

  // Splice the incoming beat into its slot so the completing beat can be
  // loaded into the holding register in the same cycle it arrives.
  always_comb begin
    asm_next = asm_q;
    asm_next[int'(beat_cnt) * AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = s_axis_h2c_tdata;
  end

  // Next-state and beat/packet counter update.
  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    pkt_cnt_next  = pkt_cnt;
    if (accept) begin
      if (xfer_end | early_last) begin
        beat_cnt_next = '0;
        pkt_cnt_next  = '0;
      end else if (last_beat) begin
        beat_cnt_next = '0;
        pkt_cnt_next  = pkt_cnt + 1'b1;
      end else begin
        beat_cnt_next = beat_cnt + 1'b1;
      end
    end
    unique case (state)
      IDLE: if (accept && !(xfer_end || early_last)) state_next = RECV;
      RECV: if (accept && (xfer_end || early_last))  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, assembly, holding register and framing status.
  always_ff @(posedge s_axis_h2c_aclk or posedge s_axis_h2c_areset) begin
    if (s_axis_h2c_areset) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      pkt_cnt    <= '0;
      asm_q      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      rx_seq     <= '0;
      err_frame  <= 1'b0;
    end else begin
      state     <= state_next;
      beat_cnt  <= beat_cnt_next;
      pkt_cnt   <= pkt_cnt_next;
      err_frame <= early_last | missing_last;
      if (accept) asm_q <= asm_next;
      if (load) data <= asm_next[DATA_WIDTH+7:8];
      if (load) data_valid <= 1'b1;
      else if (data_ready) data_valid <= 1'b0;
      if (accept && first_beat) rx_seq <= header;
    end
  end

`ifdef AXIS_UNPACK_SEQ_CHECK_EN
  logic [7:0] exp_seq;
  logic       err_seq_q;

  // Compare the transfer header against the expected number, then resync.
  always_ff @(posedge s_axis_h2c_aclk or posedge s_axis_h2c_areset) begin
    if (s_axis_h2c_areset) begin
      exp_seq   <= '0;
      err_seq_q <= 1'b0;
    end else begin
      err_seq_q <= accept & first_beat & (header != exp_seq);
      if (accept && first_beat) exp_seq <= header + 8'd1;
    end
  end

  assign err_seq = err_seq_q;
`else
  assign err_seq = 1'b0;
`endif

  // tkeep is ignored and assembly bits outside the payload are discarded.
  logic unused_bits;
  assign unused_bits = ^{s_axis_h2c_tkeep, asm_next};

endmodule

// File: tb/tb_axis_data_unpack.sv
// Randomized self-checking bench for axis_data_unpack with a transfer-level
// reference model (expected packets, error pulse counts, rx_seq).
module tb_axis_data_unpack;

  localparam int DW  = 1000;
  localparam int AW  = 512;
  localparam int PPX = 2;
  localparam int BPP = (DW + 8 + AW - 1) / AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] tdata;
  logic [63:0]   tkeep;
  logic          tlast, tvalid, tready;
  logic          data_valid, data_ready;
  logic [DW-1:0] data;
  logic [7:0]    rx_seq;
  logic          err_seq, err_frame;

  always #5 clk = ~clk;

  axis_data_unpack #(
    .DATA_WIDTH(DW),
    .AXIS_DATA_WIDTH(AW),
    .PKTS_PER_XFER(PPX)
  ) dut (
    .s_axis_h2c_aclk(clk),
    .s_axis_h2c_areset(rst),
    .s_axis_h2c_tdata(tdata),
    .s_axis_h2c_tkeep(tkeep),
    .s_axis_h2c_tlast(tlast),
    .s_axis_h2c_tvalid(tvalid),
    .s_axis_h2c_tready(tready),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data(data),
    .rx_seq(rx_seq),
    .err_seq(err_seq),
    .err_frame(err_frame)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got(lo) %0h expected(lo) %0h", tag, got[127:0], exp[127:0]);
    end
  endtask

  // Observer: packets taken by the consumer and error pulses.
  logic [DW-1:0] got_q[$];
  int frame_cnt, seq_cnt;
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid && data_ready) got_q.push_back(data);
      if (err_frame) frame_cnt++;
      if (err_seq) seq_cnt++;
    end
  end

  logic [7:0] model_seq;
  bit rand_rdy, rand_gap;

  function automatic logic [AW-1:0] rand_beat();
    logic [AW-1:0] r;
    for (int w = 0; w < AW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) data_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input logic [AW-1:0] d, input bit last, output int stalls);
    bit hs, done;
    stalls = 0;
    done   = 0;
    if (rand_gap) repeat ($urandom_range(0, 2)) tick();
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      hs = tready;
      tick();
      if (hs) done = 1;
      else stalls++;
    end
    if (!done) check("beat_timeout", done, 1);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  // kind: 0 normal, 1 tlast early at beat index cut, 2 tlast missing
  task automatic run_xfer(input int kind, input logic [7:0] seq, input int cut, output int stalls);
    logic [BPP*AW-1:0] asm [PPX];
    int nbeats, npkts, s, exp_f, exp_s;
    bit last;
    for (int p = 0; p < PPX; p++)
      for (int b = 0; b < BPP; b++) asm[p][b*AW +: AW] = rand_beat();
    asm[0][7:0] = seq;
    if (!rand_rdy) data_ready = 1'b1;
    got_q.delete();
    frame_cnt = 0;
    seq_cnt   = 0;
    stalls    = 0;
    nbeats = (kind == 1) ? cut + 1 : BPP * PPX;
    npkts  = (kind == 1) ? (cut + 1) / BPP : PPX;
    exp_f  = (kind != 0) ? 1 : 0;
`ifdef AXIS_UNPACK_SEQ_CHECK_EN
    exp_s  = (seq != model_seq) ? 1 : 0;
`else
    exp_s  = 0;
`endif
    model_seq = seq + 8'd1;
    for (int i = 0; i < nbeats; i++) begin
      last = (kind == 0 && i == nbeats - 1) || (kind == 1 && i == cut);
      send_beat(asm[i / BPP][(i % BPP)*AW +: AW], last, s);
      stalls += s;
    end
    for (int t = 0; t < 100 && got_q.size() < npkts; t++) tick();
    repeat (3) tick();
    check("npkts", got_q.size(), npkts);
    for (int i = 0; i < npkts && i < got_q.size(); i++)
      check("payload", got_q[i], asm[i][DW+7:8]);
    check("err_frame_cnt", frame_cnt, exp_f);
    check("err_seq_cnt", seq_cnt, exp_s);
    check("rx_seq", rx_seq, seq);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tready"}, tready, 1);
    check({tag, "_dvalid"}, data_valid, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_rx_seq"}, rx_seq, 0);
    check({tag, "_err_seq"}, err_seq, 0);
    check({tag, "_err_frame"}, err_frame, 0);
  endtask

  initial begin
    int st;
    logic [BPP*AW-1:0] p0, p1;

    rst = 1'b1; tdata = '0; tkeep = '1; tlast = 1'b0; tvalid = 1'b0;
    data_ready = 1'b1; rand_rdy = 0; rand_gap = 0; model_seq = 8'h00;
    frame_cnt = 0; seq_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b0;

    // Nominal transfer at full rate
    run_xfer(0, 8'h00, 0, st);
    check("nominal_stalls", st, 0);

    // Sequence numbers including wrap and a jump
    run_xfer(0, 8'hFE, 0, st);
    run_xfer(0, 8'hFF, 0, st);
    run_xfer(0, 8'h00, 0, st);
    run_xfer(0, 8'h05, 0, st);
    run_xfer(0, 8'h06, 0, st);

    // Back-pressure on the holding register
    for (int b = 0; b < BPP; b++) begin
      p0[b*AW +: AW] = rand_beat();
      p1[b*AW +: AW] = rand_beat();
    end
    p0[7:0] = model_seq;
    model_seq = model_seq + 8'd1;
    got_q.delete();
    frame_cnt = 0;
    data_ready = 1'b0;
    tvalid = 1'b1; tlast = 1'b0; tdata = p0[0 +: AW];
    @(negedge clk); check("bp_tready_b0", tready, 1); check("bp_dv_idle", data_valid, 0);
    @(posedge clk); #1; tdata = p0[AW +: AW];
    @(negedge clk); check("bp_tready_b1", tready, 1);
    @(posedge clk); #1; tdata = p1[0 +: AW];
    @(negedge clk); check("bp_dv_latency", data_valid, 1); check("bp_tready_b2", tready, 1);
    @(posedge clk); #1; tdata = p1[AW +: AW]; tlast = 1'b1;
    @(negedge clk); check("bp_stall", tready, 0);
    @(posedge clk); #1;
    @(negedge clk); check("bp_stall_hold", tready, 0); check("bp_data_hold", data, p0[DW+7:8]);
    @(posedge clk); #1; data_ready = 1'b1;
    @(negedge clk); check("bp_release", tready, 1);
    @(posedge clk); #1; tvalid = 1'b0; tlast = 1'b0;
    @(negedge clk); check("bp_dv_next", data_valid, 1); check("bp_data_next", data, p1[DW+7:8]);
    repeat (3) tick();
    check("bp_npkts", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("bp_pkt0", got_q[0], p0[DW+7:8]);
      check("bp_pkt1", got_q[1], p1[DW+7:8]);
    end
    check("bp_err_frame", frame_cnt, 0);

    // Early tlast, then a clean transfer
    run_xfer(1, model_seq, 2, st);
    run_xfer(0, model_seq, 0, st);
    // Missing tlast, then the next beat starts a transfer
    run_xfer(2, model_seq, 0, st);
    run_xfer(0, model_seq, 0, st);

    // Randomized mix with gaps and consumer back-pressure
    rand_rdy = 1;
    rand_gap = 1;
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [7:0] sq;
      k  = $urandom_range(0, 5);
      k  = (k >= 2) ? 0 : k + 1;
      sq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : model_seq;
      run_xfer(k, sq, 2 * $urandom_range(0, 1), st);
    end
    rand_rdy = 0;
    rand_gap = 0;
    data_ready = 1'b1;

    // Reset in the middle of a packet
    tvalid = 1'b1; tlast = 1'b0; tdata = rand_beat(); tdata[7:0] = 8'h33;
    @(negedge clk);
    @(posedge clk); #1;
    tvalid = 1'b0;
    @(negedge clk); check("pre_rst_rx_seq", rx_seq, 8'h33);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_seq = 8'h00;
    run_xfer(0, 8'h00, 0, st);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/axis_data_unpack.md
# axis_data_unpack

AXIS-to-packet unpacker for FPGA-difftest: the receive-side counterpart of the C2H packet packer. It accepts a 512-bit AXI-Stream carrying framed difftest packets. Each transfer holds PKTS_PER_XFER packets, each split over BEATS_PER_PKT beats with an 8-bit header byte. The block strips the header, checks sequence and framing, and presents whole DATA_WIDTH packets on a valid/ready interface to the consumer (host-mirror checker or loopback path).

## Interface
- DATA_WIDTH, 16000, payload bits per packet
- AXIS_DATA_WIDTH, 512, stream beat width
- PKTS_PER_XFER, 8, packets per AXIS transfer (tlast boundary)
- Derived, not overridable: BEATS_PER_PKT = (DATA_WIDTH + 8 + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH (32 at defaults)
- s_axis_h2c_aclk  in  1  sole clock
- s_axis_h2c_areset  in  1  reset, asynchronous, active-high
- s_axis_h2c_tdata  in  AXIS_DATA_WIDTH  beat data
- s_axis_h2c_tkeep  in  64  ignored; all bytes treated valid
- s_axis_h2c_tlast  in  1  end of transfer
- s_axis_h2c_tvalid  in  1  beat valid
- s_axis_h2c_tready  out  1  beat accepted when tvalid & tready
- data_valid  out  1  packet available
- data_ready  in  1  consumer takes packet when data_valid & data_ready
- data  out  DATA_WIDTH  packet payload
- rx_seq  out  8  header of last transfer-first packet
- err_seq  out  1  one-cycle pulse, sequence mismatch
- err_frame  out  1  one-cycle pulse, tlast misplaced

## Operation
- Packet layout: beat k occupies bits [k*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] of an assembly register. Beat 0 comes first. Bits [7:0] are the header. data = assembly[DATA_WIDTH+7:8]. Unused high bits are discarded.
- Header: packet 0 of a transfer carries the sequence number. Headers of packets 1..PKTS_PER_XFER-1 are ignored.
- Counters:
  - beat_cnt counts 0..BEATS_PER_PKT-1.
  - pkt_cnt counts 0..PKTS_PER_XFER-1.
  - exp_seq is 8 bits and wraps 255->0.
  - All three are 0 after reset.
- FSM:
  - IDLE: pkt_cnt=0, beat_cnt=0. An accepted beat goes to RECV. If BEATS_PER_PKT=1 and PKTS_PER_XFER=1, that beat also completes the transfer and the FSM stays in IDLE.
  - RECV: assembles beats. On the last beat of the last packet, goes to IDLE.
- Sequence: on beat 0 of packet 0:
  - rx_seq <= header.
  - If header != exp_seq, pulse err_seq.
  - exp_seq <= header+1 in all cases (resync).
  - The packet is delivered regardless.
- Framing:
  - tlast on the expected last beat is normal.
  - tlast earlier than expected: pulse err_frame, discard the partial packet (already completed packets stand), and go to IDLE.
  - Missing tlast on the expected last beat: pulse err_frame, deliver the packet, and go to IDLE (resync on count).
- Output holding register:
  - When the last beat of a packet is accepted, the packet moves to data and data_valid sets next cycle.
  - data_valid clears on data_valid & data_ready unless a new packet loads in the same cycle; then data_valid stays 1 with the new data.
- Back-pressure: s_axis_h2c_tready = ~(beat_cnt == BEATS_PER_PKT-1 & data_valid & ~data_ready). Non-last beats are never stalled.

## Timing
- Reset values: s_axis_h2c_tready=1, data_valid=0, data=0, rx_seq=0, err_seq=0, err_frame=0.
- Reset asserted mid-packet or mid-transfer clears everything immediately. Partial data is lost, and the next accepted beat is treated as beat 0 of packet 0.
- Latency: data_valid is high 1 cycle after the last beat handshake.
- err_seq pulses 1 cycle after the beat-0 handshake. err_frame pulses 1 cycle after the offending beat handshake.
- Throughput: one beat per cycle sustained while the consumer holds data_ready=1.
- tready is combinational from data_ready and registered state. It has no path from tvalid.

## Configuration
- AXIS_UNPACK_SEQ_CHECK_EN defined: sequence checking as above.
- Without it:
  - err_seq is tied 0.
  - exp_seq logic is removed.
  - rx_seq is still captured.

## Test plan
Bench override for all scenarios: DATA_WIDTH=1000, AXIS_DATA_WIDTH=512, PKTS_PER_XFER=2, giving BEATS_PER_PKT=2.
- Nominal: send one transfer of 4 beats with seq=0x00, tlast on beat 3, data_ready=1. Expect 2 packets with payload bits matching, then IDLE; err_seq=0, err_frame=0; rx_seq=0x00.
- Sequence wrap and error: send transfers with seq 0xFF, 0x00, 0x05. Expect no error for 0xFF then 0x00. For 0x05, expect err_seq pulsing once; a following 0x06 raises no error.
- Back-pressure: hold data_ready=0 after the first packet. Expect tready=0 only on beat 1 of packet 1. After data_ready=1, expect the packet taken and tready=1 in the same cycle.
- Early tlast: tlast on beat 2. Expect err_frame pulse, packet 0 delivered, the partial packet dropped, and the next transfer received correctly.
- Missing tlast: no tlast on beat 3. Expect err_frame pulse, packet 1 delivered, and the next beat treated as a transfer start (header checked).
- Reset mid-packet: assert areset after beat 0. Expect all outputs at reset values immediately; after release, a full transfer with seq=0x00 gives no error.
